// File: rtl/synth_alloc_pkg.sv
// -----------------------------------------------------------------------------
// synth_alloc_pkg
// Shared types for the voice allocator: FSM state encoding, the latched note
// event record, the stored key width and a ceil(log2) helper used to size the
// voice index.
// -----------------------------------------------------------------------------
package synth_alloc_pkg;

   localparam int KEY_W = 7;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DECIDE,
      ISSUE
   } alloc_state_t;

   typedef struct packed {
      logic             is_on;
      logic [KEY_W-1:0] key;
      logic [7:0]       vel;
   } alloc_evt_t;

   function automatic int clogb2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/voice_key_table.sv
// -----------------------------------------------------------------------------
// voice_key_table
// VOICES x KEY_W register file holding the key assigned to each voice.
// Ports:
//   sysclk, reset1 : clock, asynchronous active-low reset (clears all entries)
//   rd_idx/rd_key  : combinational read port (driven by the scan index)
//   wr_en/wr_idx/wr_key : single synchronous write port
// -----------------------------------------------------------------------------
module voice_key_table
   import synth_alloc_pkg::*;
#(
   parameter int VOICES  = 128,
   parameter int V_WIDTH = clogb2(VOICES)
) (
   input  logic               sysclk,
   input  logic               reset1,
   input  logic [V_WIDTH-1:0] rd_idx,
   output logic [KEY_W-1:0]   rd_key,
   input  logic               wr_en,
   input  logic [V_WIDTH-1:0] wr_idx,
   input  logic [KEY_W-1:0]   wr_key
);

   logic [KEY_W-1:0] mem [VOICES];

   always_ff @(posedge sysclk or negedge reset1) begin
      if (!reset1) begin
         for (int i = 0; i < VOICES; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_key;
      end
   end

   assign rd_key = mem[rd_idx];

endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Maps note-on/note-off events onto synth voice slots. Each accepted event is
// followed by a full round-robin scan of all voices (looking for a voice
// already holding the key and for the first available voice), one decision
// cycle, and a single valid/ready assignment to the engine.
// Ports:
//   sysclk, reset1        : clock, asynchronous active-low reset
//   ev_valid/ev_ready     : event handshake (ready only in IDLE)
//   ev_is_on/ev_key/ev_vel: event contents (ev_key[7] ignored)
//   voice_free            : per-voice envelope-finished flags, sampled live
//   alloc_*               : assignment to the engine (valid/ready)
//   keys_on/active_count  : held-voice vector and its popcount
//   drop_pulse            : one-cycle pulse when an event is discarded
//   busy                  : allocator not in IDLE
// Build option: VOICE_STEAL_EN -- when defined, a note-on with no matching and
// no available voice steals voice rr_ptr; otherwise such events are dropped.
// -----------------------------------------------------------------------------
module voice_allocator
   import synth_alloc_pkg::*;
#(
   parameter int VOICES  = 128,
   parameter int V_WIDTH = clogb2(VOICES)
) (
   input  logic               sysclk,
   input  logic               reset1,
   input  logic               ev_valid,
   output logic               ev_ready,
   input  logic               ev_is_on,
   input  logic [7:0]         ev_key,
   input  logic [7:0]         ev_vel,
   input  logic [VOICES-1:0]  voice_free,
   output logic               alloc_valid,
   input  logic               alloc_ready,
   output logic [V_WIDTH-1:0] alloc_voice,
   output logic [7:0]         alloc_key,
   output logic [7:0]         alloc_vel,
   output logic               alloc_on,
   output logic               alloc_steal,
   output logic [VOICES-1:0]  keys_on,
   output logic [V_WIDTH:0]   active_count,
   output logic               drop_pulse,
   output logic               busy
);

   alloc_state_t       state, next_state;
   alloc_evt_t         evt;
   logic [V_WIDTH-1:0] rr_ptr;
   logic [V_WIDTH-1:0] scan_n;
   logic [V_WIDTH-1:0] scan_idx;
   logic [KEY_W-1:0]   tbl_key;
   logic               match_found, free_found;
   logic [V_WIDTH-1:0] match_idx, free_idx;
   logic               dec_issue, dec_on;
   logic [V_WIDTH-1:0] dec_voice;
   logic               handshake;
   logic               unused_key_msb;

   assign unused_key_msb = ev_key[7];
   assign scan_idx       = rr_ptr + scan_n;   // wraps: VOICES is a power of two
   assign handshake      = (state == ISSUE) && alloc_ready;
   assign alloc_key      = {1'b0, evt.key};
   assign alloc_vel      = evt.vel;

   voice_key_table #(
      .VOICES  (VOICES),
      .V_WIDTH (V_WIDTH)
   ) u_table (
      .sysclk (sysclk),
      .reset1 (reset1),
      .rd_idx (scan_idx),
      .rd_key (tbl_key),
      .wr_en  (handshake && alloc_on),
      .wr_idx (alloc_voice),
      .wr_key (evt.key)
   );

`ifdef VOICE_STEAL_EN
   logic dec_steal;
   logic steal_q;
   assign alloc_steal = steal_q;
`else
   assign alloc_steal = 1'b0;
`endif

   always_ff @(posedge sysclk or negedge reset1) begin
      if (!reset1) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state  = state;
      ev_ready    = 1'b0;
      busy        = 1'b1;
      alloc_valid = 1'b0;
      drop_pulse  = 1'b0;
      dec_issue   = 1'b0;
      dec_on      = 1'b0;
      dec_voice   = '0;
`ifdef VOICE_STEAL_EN
      dec_steal   = 1'b0;
`endif
      case (state)
         IDLE: begin
            ev_ready = 1'b1;
            busy     = 1'b0;
            if (ev_valid) next_state = SCAN;
         end
         SCAN: begin
            if (scan_n == V_WIDTH'(VOICES - 1)) next_state = DECIDE;
         end
         DECIDE: begin
            if (evt.is_on) begin
               dec_on = 1'b1;
               if (match_found) begin
                  dec_issue = 1'b1;
                  dec_voice = match_idx;
               end else if (free_found) begin
                  dec_issue = 1'b1;
                  dec_voice = free_idx;
               end else begin
`ifdef VOICE_STEAL_EN
                  dec_issue = 1'b1;
                  dec_voice = rr_ptr;
                  dec_steal = 1'b1;
`endif
               end
            end else if (match_found) begin
               dec_issue = 1'b1;
               dec_voice = match_idx;
            end
            drop_pulse = !dec_issue;
            next_state = dec_issue ? ISSUE : IDLE;
         end
         ISSUE: begin
            alloc_valid = 1'b1;
            if (alloc_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge reset1) begin
      if (!reset1) begin
         evt          <= '0;
         scan_n       <= '0;
         match_found  <= 1'b0;
         free_found   <= 1'b0;
         match_idx    <= '0;
         free_idx     <= '0;
         rr_ptr       <= '0;
         keys_on      <= '0;
         active_count <= '0;
         alloc_voice  <= '0;
         alloc_on     <= 1'b0;
`ifdef VOICE_STEAL_EN
         steal_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (ev_valid) begin
                  evt         <= '{is_on: ev_is_on, key: ev_key[KEY_W-1:0], vel: ev_vel};
                  scan_n      <= '0;
                  match_found <= 1'b0;
                  free_found  <= 1'b0;
                  match_idx   <= '0;
                  free_idx    <= '0;
               end
            end
            SCAN: begin
               scan_n <= scan_n + 1'b1;
               // first hit in round-robin order wins for both searches
               if (!match_found && keys_on[scan_idx] && (tbl_key == evt.key)) begin
                  match_found <= 1'b1;
                  match_idx   <= scan_idx;
               end
               if (!free_found && voice_free[scan_idx] && !keys_on[scan_idx]) begin
                  free_found <= 1'b1;
                  free_idx   <= scan_idx;
               end
            end
            DECIDE: begin
               if (dec_issue) begin
                  alloc_voice <= dec_voice;
                  alloc_on    <= dec_on;
`ifdef VOICE_STEAL_EN
                  steal_q     <= dec_steal;
`endif
               end
            end
            ISSUE: begin
               if (alloc_ready) begin
                  if (alloc_on) begin
                     // retrigger and steal leave an already-set bit set, so
                     // only a fresh voice raises the count
                     keys_on[alloc_voice] <= 1'b1;
                     rr_ptr               <= alloc_voice + 1'b1;
                     if (!keys_on[alloc_voice] && (active_count != (V_WIDTH+1)'(VOICES)))
                        active_count <= active_count + 1'b1;
                  end else begin
                     keys_on[alloc_voice] <= 1'b0;
                     if (keys_on[alloc_voice] && (active_count != '0))
                        active_count <= active_count - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Sequences note events from the MIDI decoder onto the synth engine's voice slots.
- Accepts one note-on or note-off event at a time and scans all voices with a round-robin pointer.
- Picks a free, retriggered or stolen voice and issues a single assignment to the engine over a valid/ready handshake.
- Owns the authoritative keys_on vector and the voice-to-key table.

Parameters:
- VOICES, 128, number of voice slots; power of two, ≥2.
- V_WIDTH, clogb2(VOICES), voice index width.

Ports:
- sysclk  in  1  system clock
- reset1  in  1  asynchronous active-low reset
- ev_valid  in  1  note event offered
- ev_ready  out  1  allocator can accept an event (high only in IDLE)
- ev_is_on  in  1  1 = note-on, 0 = note-off
- ev_key  in  8  MIDI key; bit 7 ignored
- ev_vel  in  8  velocity
- voice_free  in  VOICES  per-voice "envelope finished" from the envelope generator
- alloc_valid  out  1  assignment pending
- alloc_ready  in  1  engine takes the assignment
- alloc_voice  out  V_WIDTH  target voice
- alloc_key  out  8  key for the voice
- alloc_vel  out  8  velocity
- alloc_on  out  1  1 = start/retrigger, 0 = release
- alloc_steal  out  1  assignment overrides a sounding voice
- keys_on  out  VOICES  voice currently held by a key
- active_count  out  V_WIDTH+1  popcount of keys_on
- drop_pulse  out  1  one-cycle pulse: event discarded
- busy  out  1  state ≠ IDLE

Behaviour:
- Reset (reset1 low, asynchronous):
  - All outputs 0, except ev_ready = 1.
  - Key table cleared to 0, rr_ptr = 0, state = IDLE.
  - Reset mid-scan or mid-issue abandons the event; no partial update.
- Voice "available" = voice_free[i] && !keys_on[i].
- States: IDLE -> SCAN -> DECIDE -> ISSUE -> IDLE. DECIDE may go directly to IDLE on a drop.
- IDLE:
  - ev_ready = 1.
  - ev_valid && ev_ready latches is_on, key[6:0], vel and moves to SCAN with n = 0.
- SCAN:
  - Exactly VOICES cycles; index i = (rr_ptr + n) mod VOICES.
  - Records the first i with keys_on[i] && table[i] == key (match).
  - Records the first available i (free).
  - voice_free is sampled live, per index, at its scan cycle.
- DECIDE, one cycle, note-on, in priority order:
  - match -> that voice, retrigger.
  - else free -> first free voice.
  - else steal rule (see Optional Feature).
- DECIDE, note-off:
  - match -> release that voice.
  - else drop_pulse and go to IDLE.
- ISSUE:
  - alloc_valid held high with all alloc_* stable until alloc_ready.
  - On the handshake cycle:
    - note-on: set keys_on[v], write table[v] = key, rr_ptr = (v+1) mod VOICES (wraps).
    - note-off: clear keys_on[v].
  - Next state IDLE.
- Latency: accept-to-first-alloc_valid = VOICES+2 cycles; ev_ready returns the cycle after the alloc handshake.
- active_count: +1 on a new allocation, −1 on a release; unchanged on retrigger or steal; never wraps.
- Duplicate note-off (key no longer held): drop, no state change.
- Note-on with VOICES voices held and all matching another key: steal rule applies.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined:
  - Note-on with no match and no free voice assigns voice rr_ptr.
  - alloc_steal = 1; table and rr_ptr updated as normal; keys_on bit remains set.
- Undefined:
  - Same case gives drop_pulse and no issue.
  - alloc_steal tied to 0.

Decomposition:
- Package synth_alloc_pkg:
  - alloc_state_t enum {IDLE, SCAN, DECIDE, ISSUE}.
  - alloc_evt_t struct {is_on, key[6:0], vel[7:0]}.
  - KEY_W = 7.
- Sub-module voice_key_table:
  - VOICES×7 register file.
  - Combinational read port at scan index, one synchronous write port.
  - Async reset to 0.

Test Plan (VOICES=8, all voice_free=1 unless stated):
- Reset mid-ISSUE with alloc_ready=0 -> next cycle keys_on=0, alloc_valid=0, ev_ready=1, active_count=0.
- Note-on key 60 vel 100 -> alloc_valid asserted 10 cycles after accept; voice 0, alloc_on=1, steal=0. After handshake keys_on=8'h01, rr_ptr=1, active_count=1.
- Note-ons 60,62,64 then note-on 62 again -> fourth event retriggers voice 1 (alloc_on=1, steal=0); active_count stays 3.
- Note-off 62 -> voice 1, alloc_on=0, keys_on=8'h05. A second note-off 62 -> drop_pulse once, no alloc_valid.
- 8 distinct note-ons, then key 70:
  - With VOICE_STEAL_EN: voice 0 (rr_ptr wrapped to 0), alloc_steal=1, count=8.
  - Without it: drop_pulse, no issue.
- voice_free=8'b1111_1100, rr_ptr=0, note-on -> voice 2. Holding alloc_ready=0 for 5 cycles keeps all alloc_* stable and ev_ready=0.
